// File: rtl/move_flipper.sv
// move_flipper: places a piece, scans all eight directions for captures and
// flips them through the board RAM, then pulses next_turn or illegal.
module move_flipper #(
  parameter int DIM_BITS = 3,
  parameter int COUNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DIM_BITS-1:0]   move_x,
  input  logic [DIM_BITS-1:0]   move_y,
  input  logic                  colour,
  output logic [2*DIM_BITS-1:0] rd_addr,
  input  logic [1:0]            rd_data,
  output logic                  wr_en,
  output logic [2*DIM_BITS-1:0] wr_addr,
  output logic [1:0]            wr_data,
  output logic                  busy,
  output logic                  next_turn,
  output logic                  illegal,
  output logic [COUNT_W-1:0]    flip_count
);
  localparam int PW = DIM_BITS + 1;
  typedef enum logic [3:0] {
    S_IDLE, S_CHK_CELL, S_CHK_WAIT, S_SCAN, S_SCAN_WAIT,
    S_FLIP, S_NEXT_DIR, S_PLACE, S_DONE, S_ILLEGAL
  } state_t;
  state_t                r_state, w_next;
  logic [DIM_BITS-1:0]   r_x, r_y, r_cx, r_cy, w_bx, w_by;
  logic                  r_col;
  logic [2:0]            r_dir, r_run;
  logic [COUNT_W-1:0]    r_total, r_flip_count;
  logic [1:0]            r_wr_data;
  logic [PW-1:0]         w_dx, w_dy, w_nx, w_ny;
  logic                  w_off, w_own;
  // Direction 0 is north (dy=-1), then clockwise; '1 is -1 in PW bits.
  assign w_dx  = (r_dir inside {3'd1, 3'd2, 3'd3}) ? PW'(1) :
                 (r_dir inside {3'd5, 3'd6, 3'd7}) ? '1 : '0;
  assign w_dy  = (r_dir inside {3'd3, 3'd4, 3'd5}) ? PW'(1) :
                 (r_dir inside {3'd7, 3'd0, 3'd1}) ? '1 : '0;
  assign w_nx  = {1'b0, r_cx} + w_dx;
  assign w_ny  = {1'b0, r_cy} + w_dy;
  assign w_off = w_nx[DIM_BITS] | w_ny[DIM_BITS];
  assign w_bx  = r_cx - w_dx[DIM_BITS-1:0];
  assign w_by  = r_cy - w_dy[DIM_BITS-1:0];
  assign w_own = rd_data[0] == r_col;
  always_ff @(posedge clk or posedge resetn)
    if (resetn) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = start ? S_CHK_CELL : S_IDLE;
      S_CHK_CELL:  w_next = S_CHK_WAIT;
      S_CHK_WAIT:  w_next = rd_data[1] ? S_ILLEGAL : S_SCAN;
      S_SCAN:      w_next = w_off ? S_NEXT_DIR : S_SCAN_WAIT;
      S_SCAN_WAIT: w_next = !rd_data[1] ? S_NEXT_DIR : !w_own ? S_SCAN :
                            (r_run == 3'd0) ? S_NEXT_DIR : S_FLIP;
      S_FLIP:      w_next = (r_run == 3'd1) ? S_NEXT_DIR : S_FLIP;
      S_NEXT_DIR:  w_next = (r_dir != 3'd7) ? S_SCAN :
                            (r_total != '0) ? S_PLACE : S_ILLEGAL;
      S_PLACE:     w_next = S_DONE;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge resetn)
    if (resetn) begin
      r_x          <= '0;
      r_y          <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_col        <= 1'b0;
      r_dir        <= '0;
      r_run        <= '0;
      r_total      <= '0;
      r_flip_count <= '0;
      r_wr_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x       <= move_x;
          r_y       <= move_y;
          r_cx      <= move_x;
          r_cy      <= move_y;
          r_col     <= colour;
          r_wr_data <= {1'b1, colour};
          r_total   <= '0;
        end
        S_CHK_WAIT: begin
          r_dir <= '0;
          r_run <= '0;
        end
        S_SCAN: if (!w_off) begin
          r_cx <= w_nx[DIM_BITS-1:0];
          r_cy <= w_ny[DIM_BITS-1:0];
        end
        S_SCAN_WAIT:
          if (rd_data[1] && !w_own) r_run <= r_run + 3'd1;
          else if (rd_data[1] && r_run != 3'd0) r_total <= r_total + COUNT_W'(r_run);
        S_FLIP: begin
          r_cx  <= w_bx;
          r_cy  <= w_by;
          r_run <= r_run - 3'd1;
        end
        S_NEXT_DIR: begin
          r_dir <= r_dir + 3'd1;
          r_cx  <= r_x;
          r_cy  <= r_y;
          r_run <= '0;
        end
        S_DONE: r_flip_count <= r_total;
        default: ;
      endcase
    end
  // The scan read address is driven combinationally so data returns in SCAN_WAIT.
  assign rd_addr    = (r_state == S_SCAN && !w_off) ? {w_ny[DIM_BITS-1:0], w_nx[DIM_BITS-1:0]}
                                                    : {r_cy, r_cx};
  assign wr_en      = (r_state == S_FLIP) || (r_state == S_PLACE);
  assign wr_addr    = (r_state == S_FLIP) ? {w_by, w_bx} : (r_state == S_PLACE) ? {r_y, r_x} : '0;
  assign wr_data    = r_wr_data;
  assign busy       = !(r_state inside {S_IDLE, S_DONE, S_ILLEGAL});
  assign next_turn  = r_state == S_DONE;
  assign illegal    = r_state == S_ILLEGAL;
  assign flip_count = r_flip_count;
endmodule

// File: tb/tb_move_flipper.sv
// tb_move_flipper: drives move_flipper against a bench-side board RAM and a
// direction-walking reference of the capture rules.
module tb_move_flipper;
  logic       clk = 0, resetn = 1, start = 0, colour = 0;
  logic [2:0] move_x = 0, move_y = 0;
  logic [5:0] rd_addr, wr_addr, flip_count;
  logic [1:0] rd_data = 0, wr_data;
  logic       wr_en, busy, next_turn, illegal;
  logic [1:0] mem [64];
  logic [7:0] wlog[$];
  int         exp_q[$];
  int         n_chk = 0, n_pass = 0, n_turn, n_ill, lat, exp_fc = 0;
  bit         both_err, busy_err;

  typedef struct {int x; int y; logic c; bit legal; int fc;} vec_t;
  vec_t tbl[5];

  move_flipper dut (
    .clk(clk), .resetn(resetn), .start(start), .move_x(move_x), .move_y(move_y),
    .colour(colour), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .next_turn(next_turn),
    .illegal(illegal), .flip_count(flip_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (wr_en) wlog.push_back({wr_addr, wr_data});
    if (next_turn) n_turn++;
    if (illegal) n_ill++;
    if (next_turn && illegal) both_err = 1;
    if ((next_turn || illegal) && busy) busy_err = 1;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
  endtask

  task automatic init_board();
    clear_board();
    mem[27] = 2'b11; mem[28] = 2'b10; mem[35] = 2'b10; mem[36] = 2'b11;
  endtask

  // Expected write stream: per direction, captured cells outermost first, then the placed cell.
  task automatic ref_move(input int x, input int y, input logic c, output int cnt);
    int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    logic [1:0] own, opp;
    own = {1'b1, c};
    opp = {1'b1, ~c};
    exp_q.delete();
    cnt = 0;
    if (mem[y*8+x][1]) return;
    for (int d = 0; d < 8; d++) begin
      int px, py;
      int cells[$];
      px = x + dxs[d];
      py = y + dys[d];
      while (px >= 0 && px < 8 && py >= 0 && py < 8 && mem[py*8+px] == opp) begin
        cells.push_back(py*8+px);
        px += dxs[d];
        py += dys[d];
      end
      if (px >= 0 && px < 8 && py >= 0 && py < 8 && mem[py*8+px] == own && cells.size() > 0) begin
        for (int i = cells.size() - 1; i >= 0; i--) exp_q.push_back((cells[i] << 2) | 2 | int'(c));
        cnt += cells.size();
      end
    end
    if (cnt > 0) exp_q.push_back(((y*8+x) << 2) | 2 | int'(c));
  endtask

  task automatic do_move(input int x, input int y, input logic c, input bit glitch, output bit to);
    wlog.delete();
    n_turn = 0; n_ill = 0; lat = 0; both_err = 0; busy_err = 0;
    tick();
    move_x = 3'(x); move_y = 3'(y); colour = c; start = 1;
    tick();
    start = 0; lat = 1;
    if (glitch) begin
      chk("busy_after_start", int'(busy), 1);
      repeat (3) tick();
      start = 1; colour = ~c; move_x = 0; move_y = 0;
      tick();
      start = 0; lat += 4;
    end
    while (n_turn == 0 && n_ill == 0 && lat < 3000) begin
      tick();
      lat++;
    end
    to = (n_turn == 0 && n_ill == 0);
    repeat (2) tick();
  endtask

  task automatic verify_move(input string nm, input int x, input int y, input logic c,
                             input bit glitch, output int cnt);
    bit to;
    ref_move(x, y, c, cnt);
    do_move(x, y, c, glitch, to);
    chk({nm, "_timeout"}, int'(to), 0);
    chk({nm, "_next_turn"}, n_turn, int'(cnt > 0));
    chk({nm, "_illegal"}, n_ill, int'(cnt == 0));
    if (cnt > 0) exp_fc = cnt;
    chk({nm, "_flip_count"}, int'(flip_count), exp_fc);
    chk({nm, "_wr_count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", nm, i), int'(wlog[i]), exp_q[i]);
    chk({nm, "_pulse_overlap"}, int'(both_err), 0);
    chk({nm, "_busy_at_pulse"}, int'(busy_err), 0);
  endtask

  initial begin
    int cnt, k;
    int exp_w[5];
    tbl[0] = '{3, 2, 1'b0, 1'b1, 1};
    tbl[1] = '{3, 3, 1'b0, 1'b0, 1};
    tbl[2] = '{0, 0, 1'b0, 1'b0, 1};
    tbl[3] = '{2, 2, 1'b1, 1'b1, 1};
    tbl[4] = '{1, 1, 1'b0, 1'b0, 1};
    init_board();
    #12;
    chk("reset_outputs", int'({wr_en, busy, next_turn, illegal, rd_addr, wr_addr, wr_data, flip_count}), 0);
    @(negedge clk);
    resetn = 0;

    for (int i = 0; i < 5; i++) begin
      verify_move($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].c, 1'b0, cnt);
      chk($sformatf("vec%0d_legal", i), int'(cnt > 0), int'(tbl[i].legal));
      chk($sformatf("vec%0d_fc_const", i), int'(flip_count), tbl[i].fc);
      if (i == 1) chk("occupied_latency_ok", int'(lat >= 2 && lat <= 4), 1);
    end

    // Multi-direction capture with a stray start and colour change while busy.
    clear_board();
    mem[18] = 2'b11; mem[20] = 2'b11; mem[37] = 2'b11;
    mem[26] = 2'b10; mem[27] = 2'b10; mem[35] = 2'b10; mem[36] = 2'b10;
    exp_w = '{26, 27, 36, 35, 34};
    verify_move("multi", 2, 4, 1'b1, 1'b1, cnt);
    chk("multi_fc_const", int'(flip_count), 4);
    chk("multi_wr_count_const", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk($sformatf("multi_const_wr%0d", i), int'(wlog[i]), (exp_w[i] << 2) | 3);

    // Reset asserted while flipping.
    clear_board();
    mem[18] = 2'b11; mem[20] = 2'b11; mem[37] = 2'b11;
    mem[26] = 2'b10; mem[27] = 2'b10; mem[35] = 2'b10; mem[36] = 2'b10;
    wlog.delete();
    tick();
    move_x = 2; move_y = 4; colour = 1; start = 1;
    tick();
    start = 0;
    k = 0;
    while (wlog.size() == 0 && k < 200) begin
      tick();
      k++;
    end
    chk("rst_reached_flip", int'(wlog.size() > 0), 1);
    #2 resetn = 1;
    #1 chk("rst_async_outputs",
           int'({wr_en, busy, next_turn, illegal, rd_addr, wr_addr, wr_data, flip_count}), 0);
    wlog.delete();
    repeat (3) tick();
    chk("rst_no_writes", wlog.size(), 0);
    resetn = 0;
    exp_fc = 0;
    verify_move("post_rst", 2, 4, 1'b1, 1'b0, cnt);

    // Random boards and moves against the reference.
    for (int t = 0; t < 40; t++) begin
      int x, y;
      logic c;
      for (int i = 0; i < 64; i++) begin
        int r;
        r = $urandom_range(9);
        mem[i] = (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : 2'b11;
      end
      x = $urandom_range(7);
      y = $urandom_range(7);
      c = 1'($urandom_range(1));
      if ($urandom_range(4) != 0) mem[y*8+x] = 2'b00;
      verify_move($sformatf("rnd%0d", t), x, y, c, 1'b0, cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
